// File: rtl/rst_code_pkg.sv
// Shared definitions for the serial reset-code link. The sync-side encoder
// imports the same code constants so both ends agree on the frame patterns.
// Optional statistics outputs are enabled by defining RST_DECODE_STATS_EN.
package rst_code_pkg;

  localparam int                       RST_CODE_BITS   = 4;
  localparam logic [RST_CODE_BITS-1:0] RST_IDLE_CODE   = 4'b1010;
  localparam logic [RST_CODE_BITS-1:0] RST_ACTIVE_CODE = 4'b1100;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

  // The idle stream alternates, so any 4-bit window of it reads 1010 or 0101.
  function automatic logic is_idle_any_phase(input logic [RST_CODE_BITS-1:0] win);
    return (win == RST_IDLE_CODE) || (win == ~RST_IDLE_CODE);
  endfunction

endpackage

// File: rtl/rst_code_decoder_if.sv
// Signal bundle between the reset-code line and backend logic.
// master: drives the serial code bit and observes the decoder outputs.
// slave:  the decoder itself.
// With RST_DECODE_STATS_EN defined, err_count/active_count are added.
interface rst_code_decoder_if;

  logic rst_in;
  logic locked;
  logic rst_pulse;
  logic rst_out;
  logic frame_err;
`ifdef RST_DECODE_STATS_EN
  logic [15:0] err_count;
  logic [15:0] active_count;

  modport master (
    output rst_in,
    input  locked, rst_pulse, rst_out, frame_err, err_count, active_count
  );

  modport slave (
    input  rst_in,
    output locked, rst_pulse, rst_out, frame_err, err_count, active_count
  );
`else
  modport master (
    output rst_in,
    input  locked, rst_pulse, rst_out, frame_err
  );

  modport slave (
    input  rst_in,
    output locked, rst_pulse, rst_out, frame_err
  );
`endif

endinterface

// File: rtl/rst_stretch.sv
// Stretches a one-cycle load strobe into a reset of RST_HOLD clocks.
// rst_out rises on the same edge as the decoder's rst_pulse; the counter
// holds the number of high cycles still to follow, so it is loaded with
// RST_HOLD-1. A load during a hold restarts the full hold time.
module rst_stretch #(
  parameter int RST_HOLD = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  output logic o_rst_out
);

  localparam int                HOLD_W      = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(RST_HOLD - 1);

  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_rst_out;

  // Hold counter: reload on request, count down to zero and stop there.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_cnt <= '0;
      r_rst_out  <= 1'b0;
    end else if (i_load) begin
      r_hold_cnt <= HOLD_RELOAD;
      r_rst_out  <= 1'b1;
    end else if (r_hold_cnt != '0) begin
      r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
      r_rst_out  <= 1'b1;
    end else begin
      r_rst_out  <= 1'b0;
    end
  end

  assign o_rst_out = r_rst_out;

endmodule

// File: rtl/rst_code_decoder.sv
// Backend receiver for the serial reset-code line. Recovers 4-bit frame
// alignment from the idle pattern, decodes ACTIVE frames into a one-cycle
// rst_pulse plus a stretched rst_out, and flags bad frames while locked.
// Define RST_DECODE_STATS_EN to add saturating err_count/active_count.
module rst_code_decoder
  import rst_code_pkg::*;
#(
  parameter int LOCK_FRAMES = 8,
  parameter int ERR_LIMIT   = 4,
  parameter int RST_HOLD    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  rst_code_decoder_if.slave  bus
);

  localparam int ALIGN_TARGET = RST_CODE_BITS * LOCK_FRAMES;
  localparam int ALIGN_W      = $clog2(ALIGN_TARGET + 1);
  localparam int ERR_W        = $clog2(ERR_LIMIT + 1);
  localparam int PHASE_W      = $clog2(RST_CODE_BITS);

  localparam logic [ALIGN_W-1:0] ALIGN_MAX = ALIGN_W'(ALIGN_TARGET);
  localparam logic [ERR_W-1:0]   ERR_MAX   = ERR_W'(ERR_LIMIT);
  // Phase value for the cycle after a boundary.
  localparam logic [PHASE_W-1:0] PHASE_AFTER_BOUNDARY = PHASE_W'(1);

  logic                     r_in_q;
  logic [RST_CODE_BITS-1:0] r_sr;
  lock_state_t              r_state,     w_state_nxt;
  logic [ALIGN_W-1:0]       r_align_cnt, w_align_cnt_nxt;
  logic [ERR_W-1:0]         r_err_cnt,   w_err_cnt_nxt;
  logic [PHASE_W-1:0]       r_phase,     w_phase_nxt;
  logic                     r_rst_pulse, w_rst_pulse_nxt;
  logic                     r_frame_err, w_frame_err_nxt;

  logic                     w_is_idle;
  logic                     w_is_alt;
  logic                     w_is_active;
  logic                     w_boundary;
  logic [ALIGN_W-1:0]       w_align_inc;
  logic [ERR_W-1:0]         w_err_inc;
  logic                     w_rst_out;

  assign w_is_idle   = (r_sr == RST_IDLE_CODE);
  assign w_is_alt    = is_idle_any_phase(r_sr);
  assign w_is_active = (r_sr == RST_ACTIVE_CODE);
  assign w_boundary  = (r_phase == '0);
  assign w_align_inc = (r_align_cnt == ALIGN_MAX) ? r_align_cnt : r_align_cnt + ALIGN_W'(1);
  assign w_err_inc   = (r_err_cnt == ERR_MAX)     ? r_err_cnt   : r_err_cnt + ERR_W'(1);

  // Input retiming and 4-bit sliding window, MSB first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_q <= 1'b0;
      r_sr   <= '0;
    end else begin
      r_in_q <= bus.rst_in;
      r_sr   <= {r_sr[RST_CODE_BITS-2:0], r_in_q};
    end
  end

  // Lock FSM state, counters and registered strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= UNLOCKED;
      r_align_cnt <= '0;
      r_err_cnt   <= '0;
      r_phase     <= '0;
      r_rst_pulse <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_align_cnt <= w_align_cnt_nxt;
      r_err_cnt   <= w_err_cnt_nxt;
      r_phase     <= w_phase_nxt;
      r_rst_pulse <= w_rst_pulse_nxt;
      r_frame_err <= w_frame_err_nxt;
    end
  end

  // Next-state logic: alignment search while unlocked; frame checking and
  // phase realignment on ACTIVE windows while locked.
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_align_cnt_nxt = r_align_cnt;
    w_err_cnt_nxt   = r_err_cnt;
    w_phase_nxt     = r_phase + PHASE_W'(1);
    w_rst_pulse_nxt = 1'b0;
    w_frame_err_nxt = 1'b0;

    case (r_state)
      UNLOCKED: begin
        // ACTIVE windows are deliberately ignored here: no false power-up reset.
        w_err_cnt_nxt   = '0;
        w_align_cnt_nxt = w_is_alt ? w_align_inc : '0;
        if ((r_align_cnt == ALIGN_MAX) && w_is_idle) begin
          w_state_nxt     = LOCKED;
          w_align_cnt_nxt = '0;
          w_phase_nxt     = PHASE_AFTER_BOUNDARY;
        end
      end
      LOCKED: begin
        w_align_cnt_nxt = '0;
        if (w_is_active) begin
          // Sliding match resolves the 2-bit ambiguity of the idle pattern.
          w_rst_pulse_nxt = 1'b1;
          w_phase_nxt     = PHASE_AFTER_BOUNDARY;
          w_err_cnt_nxt   = '0;
        end else if (w_boundary) begin
          if (w_is_idle) begin
            w_err_cnt_nxt = '0;
          end else begin
            w_frame_err_nxt = 1'b1;
            w_err_cnt_nxt   = w_err_inc;
            if (w_err_inc == ERR_MAX) begin
              w_state_nxt   = UNLOCKED;
              w_err_cnt_nxt = '0;
            end
          end
        end
      end
      default: begin
        w_state_nxt = UNLOCKED;
      end
    endcase
  end

  rst_stretch #(
    .RST_HOLD (RST_HOLD)
  ) u_stretch (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_rst_pulse_nxt),
    .o_rst_out (w_rst_out)
  );

  assign bus.locked    = (r_state == LOCKED);
  assign bus.rst_pulse = r_rst_pulse;
  assign bus.rst_out   = w_rst_out;
  assign bus.frame_err = r_frame_err;

`ifdef RST_DECODE_STATS_EN
  logic [15:0] r_err_count;
  logic [15:0] r_active_count;

  // Saturating event counters; cleared only by rst_n, not by lock loss.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_count    <= '0;
      r_active_count <= '0;
    end else begin
      if (w_frame_err_nxt && (r_err_count != 16'hFFFF)) begin
        r_err_count <= r_err_count + 16'd1;
      end
      if (w_rst_pulse_nxt && (r_active_count != 16'hFFFF)) begin
        r_active_count <= r_active_count + 16'd1;
      end
    end
  end

  assign bus.err_count    = r_err_count;
  assign bus.active_count = r_active_count;
`endif

endmodule
